// File: rtl/top_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : top_cpu_pkg
//  Description : Shared constants for top_cpu. Holds the MIPS-I opcode and
//                funct encodings, the bus SIZE codes, the FSM state enum and
//                a sign-extension helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package top_cpu_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_WB    = 2'd3
    } state_t;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] c_op_special = 6'h00;
    localparam logic [5:0] c_op_j       = 6'h02;
    localparam logic [5:0] c_op_jal     = 6'h03;
    localparam logic [5:0] c_op_beq     = 6'h04;
    localparam logic [5:0] c_op_bne     = 6'h05;
    localparam logic [5:0] c_op_addi    = 6'h08;
    localparam logic [5:0] c_op_addiu   = 6'h09;
    localparam logic [5:0] c_op_slti    = 6'h0A;
    localparam logic [5:0] c_op_sltiu   = 6'h0B;
    localparam logic [5:0] c_op_andi    = 6'h0C;
    localparam logic [5:0] c_op_ori     = 6'h0D;
    localparam logic [5:0] c_op_xori    = 6'h0E;
    localparam logic [5:0] c_op_lui     = 6'h0F;
    localparam logic [5:0] c_op_lb      = 6'h20;
    localparam logic [5:0] c_op_lh      = 6'h21;
    localparam logic [5:0] c_op_lw      = 6'h23;
    localparam logic [5:0] c_op_lbu     = 6'h24;
    localparam logic [5:0] c_op_lhu     = 6'h25;
    localparam logic [5:0] c_op_sb      = 6'h28;
    localparam logic [5:0] c_op_sh      = 6'h29;
    localparam logic [5:0] c_op_sw      = 6'h2B;

    // SPECIAL funct codes (IR[5:0])
    localparam logic [5:0] c_fn_sll  = 6'h00;
    localparam logic [5:0] c_fn_srl  = 6'h02;
    localparam logic [5:0] c_fn_sra  = 6'h03;
    localparam logic [5:0] c_fn_sllv = 6'h04;
    localparam logic [5:0] c_fn_srlv = 6'h06;
    localparam logic [5:0] c_fn_srav = 6'h07;
    localparam logic [5:0] c_fn_jr   = 6'h08;
    localparam logic [5:0] c_fn_jalr = 6'h09;
    localparam logic [5:0] c_fn_add  = 6'h20;
    localparam logic [5:0] c_fn_addu = 6'h21;
    localparam logic [5:0] c_fn_sub  = 6'h22;
    localparam logic [5:0] c_fn_subu = 6'h23;
    localparam logic [5:0] c_fn_and  = 6'h24;
    localparam logic [5:0] c_fn_or   = 6'h25;
    localparam logic [5:0] c_fn_xor  = 6'h26;
    localparam logic [5:0] c_fn_nor  = 6'h27;
    localparam logic [5:0] c_fn_slt  = 6'h2A;
    localparam logic [5:0] c_fn_sltu = 6'h2B;

    // Bus SIZE encodings
    localparam logic [1:0] c_size_word = 2'b00;
    localparam logic [1:0] c_size_half = 2'b01;
    localparam logic [1:0] c_size_byte = 2'b10;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/top_cpu_if.sv
`default_nettype none
// ============================================================================
//  Module      : top_cpu_if
//  Description : Instruction/data bus bundle of top_cpu (except the
//                bidirectional DDT bus, which is a plain inout port).
//  Revision    : 1.0 - initial release
// ============================================================================
interface top_cpu_if;
    logic [31:0] IAD;
    logic [31:0] IDT;
    logic        ACKI_n;
    logic [31:0] DAD;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    logic        ACKD_n;
    logic [2:0]  OINT_n;
    logic        IACK_n;

    modport master (
        output IAD, DAD, MREQ, WRITE, SIZE, IACK_n,
        input  IDT, ACKI_n, ACKD_n, OINT_n
    );

    modport slave (
        input  IAD, DAD, MREQ, WRITE, SIZE, IACK_n,
        output IDT, ACKI_n, ACKD_n, OINT_n
    );
endinterface
`default_nettype wire

// File: rtl/rf32x32.sv
`default_nettype none
// ============================================================================
//  Module      : rf32x32
//  Description : 32 x 32-bit register file, two asynchronous read ports, one
//                synchronous write port. r0 always reads zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf32x32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] r_regs [0:31];

    // Clear every register on reset; writes to r0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            r_regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'h0 : r_regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'h0 : r_regs[ra2];
endmodule
`default_nettype wire

// File: rtl/top_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : top_cpu
//  Description : Multicycle, non-pipelined MIPS-I subset core.
//                FETCH -> EXEC -> (MEM) -> WB -> FETCH.
//  Revision    : 1.0 - initial release
// ============================================================================
module top_cpu
    import top_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    top_cpu_if.master   bus,
    inout  wire  [31:0] DDT
);
    state_t      r_state, w_next_state;
    logic [31:0] r_pc, r_ir, r_result, r_npc, r_store;
    logic [4:0]  r_wdst;
    logic        r_wen, r_write, r_sgn;
    logic [1:0]  r_size;

    logic [31:0] w_rs_val, w_rt_val, w_pc4, w_simm, w_ea, w_load;
    logic [31:0] w_res, w_npc, w_store;
    logic [4:0]  w_wdst;
    logic        w_wen, w_mem, w_wr, w_sgn, w_mreq;
    logic [1:0]  w_sz;

    wire  [5:0]  w_op    = r_ir[31:26];
    wire  [4:0]  w_rs    = r_ir[25:21];
    wire  [4:0]  w_rt    = r_ir[20:16];
    wire  [4:0]  w_rd    = r_ir[15:11];
    wire  [4:0]  w_sa    = r_ir[10:6];
    wire  [5:0]  w_funct = r_ir[5:0];
    wire  [15:0] w_imm   = r_ir[15:0];
    wire         w_unused_oint = ^bus.OINT_n;

    rf32x32 u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (w_rs),
        .ra2 (w_rt),
        .rd1 (w_rs_val),
        .rd2 (w_rt_val),
        .we  ((r_state == S_WB) && r_wen),
        .wa  (r_wdst),
        .wd  (r_result)
    );

    assign w_pc4  = r_pc + 32'd4;
    assign w_simm = sext16(w_imm);
    assign w_ea   = w_rs_val + w_simm;

    // Bus outputs: data-side signals are idle (zero) outside MEM
    assign w_mreq     = (r_state == S_MEM);
    assign bus.IAD    = r_pc;
    assign bus.MREQ   = w_mreq;
    assign bus.WRITE  = w_mreq & r_write;
    assign bus.SIZE   = w_mreq ? r_size : c_size_word;
    assign bus.DAD    = w_mreq ? r_result : 32'h0;
    assign bus.IACK_n = 1'b1;
    assign DDT        = (w_mreq && r_write) ? r_store : 32'hzzzz_zzzz;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: if (!bus.ACKI_n) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = w_mem ? S_MEM : S_WB;
            S_MEM:   if (!bus.ACKD_n) w_next_state = S_WB;
            S_WB:    w_next_state = S_FETCH;
            default: w_next_state = S_FETCH;
        endcase
    end

    // Decode/execute: result, next PC, writeback target and memory controls
    always_comb begin
        w_res   = 32'h0;
        w_npc   = w_pc4;
        w_wen   = 1'b0;
        w_wdst  = w_rt;
        w_mem   = 1'b0;
        w_wr    = 1'b0;
        w_sz    = c_size_word;
        w_sgn   = 1'b0;
        w_store = w_rt_val;
        case (w_op)
            c_op_special: begin
                w_wdst = w_rd;
                w_wen  = 1'b1;
                case (w_funct)
                    c_fn_sll:  w_res = w_rt_val << w_sa;
                    c_fn_srl:  w_res = w_rt_val >> w_sa;
                    c_fn_sra:  w_res = $signed(w_rt_val) >>> w_sa;
                    c_fn_sllv: w_res = w_rt_val << w_rs_val[4:0];
                    c_fn_srlv: w_res = w_rt_val >> w_rs_val[4:0];
                    c_fn_srav: w_res = $signed(w_rt_val) >>> w_rs_val[4:0];
                    c_fn_jr:   begin w_wen = 1'b0; w_npc = w_rs_val; end
                    c_fn_jalr: begin w_res = w_pc4; w_npc = w_rs_val; end
                    c_fn_add, c_fn_addu: w_res = w_rs_val + w_rt_val;
                    c_fn_sub, c_fn_subu: w_res = w_rs_val - w_rt_val;
                    c_fn_and:  w_res = w_rs_val & w_rt_val;
                    c_fn_or:   w_res = w_rs_val | w_rt_val;
                    c_fn_xor:  w_res = w_rs_val ^ w_rt_val;
                    c_fn_nor:  w_res = ~(w_rs_val | w_rt_val);
                    c_fn_slt:  w_res = {31'h0, $signed(w_rs_val) < $signed(w_rt_val)};
                    c_fn_sltu: w_res = {31'h0, w_rs_val < w_rt_val};
                    default:   w_wen = 1'b0;
                endcase
            end
            c_op_j:   w_npc = {w_pc4[31:28], r_ir[25:0], 2'b00};
            c_op_jal: begin
                w_npc  = {w_pc4[31:28], r_ir[25:0], 2'b00};
                w_res  = w_pc4;
                w_wen  = 1'b1;
                w_wdst = 5'd31;
            end
            c_op_beq: if (w_rs_val == w_rt_val) w_npc = w_pc4 + {w_simm[29:0], 2'b00};
            c_op_bne: if (w_rs_val != w_rt_val) w_npc = w_pc4 + {w_simm[29:0], 2'b00};
            c_op_addi, c_op_addiu: begin w_res = w_ea; w_wen = 1'b1; end
            c_op_slti:  begin w_res = {31'h0, $signed(w_rs_val) < $signed(w_simm)}; w_wen = 1'b1; end
            c_op_sltiu: begin w_res = {31'h0, w_rs_val < w_simm}; w_wen = 1'b1; end
            c_op_andi:  begin w_res = w_rs_val & {16'h0, w_imm}; w_wen = 1'b1; end
            c_op_ori:   begin w_res = w_rs_val | {16'h0, w_imm}; w_wen = 1'b1; end
            c_op_xori:  begin w_res = w_rs_val ^ {16'h0, w_imm}; w_wen = 1'b1; end
            c_op_lui:   begin w_res = {w_imm, 16'h0}; w_wen = 1'b1; end
            c_op_lb, c_op_lbu, c_op_lh, c_op_lhu, c_op_lw: begin
                w_res = w_ea;
                w_wen = 1'b1;
                w_mem = 1'b1;
                w_sgn = (w_op == c_op_lb) || (w_op == c_op_lh);
                if (w_op == c_op_lb || w_op == c_op_lbu)      w_sz = c_size_byte;
                else if (w_op == c_op_lh || w_op == c_op_lhu) w_sz = c_size_half;
            end
            c_op_sb: begin w_res = w_ea; w_mem = 1'b1; w_wr = 1'b1; w_sz = c_size_byte; w_store = {24'h0, w_rt_val[7:0]}; end
            c_op_sh: begin w_res = w_ea; w_mem = 1'b1; w_wr = 1'b1; w_sz = c_size_half; w_store = {16'h0, w_rt_val[15:0]}; end
            c_op_sw: begin w_res = w_ea; w_mem = 1'b1; w_wr = 1'b1; end
            default: ;
        endcase
    end

    // Extend the captured load data according to access size and signedness
    always_comb begin
        w_load = DDT;
        case (r_size)
            c_size_byte: w_load = r_sgn ? {{24{DDT[7]}}, DDT[7:0]} : {24'h0, DDT[7:0]};
            c_size_half: w_load = r_sgn ? {{16{DDT[15]}}, DDT[15:0]} : {16'h0, DDT[15:0]};
            default:     w_load = DDT;
        endcase
    end

    // Datapath registers: IR at fetch, decoded controls at exec, load data at
    // ack, PC at writeback. Reset discards any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_ir     <= 32'h0;
            r_result <= 32'h0;
            r_npc    <= RESET_PC;
            r_store  <= 32'h0;
            r_wdst   <= 5'd0;
            r_wen    <= 1'b0;
            r_write  <= 1'b0;
            r_sgn    <= 1'b0;
            r_size   <= c_size_word;
        end else begin
            case (r_state)
                S_FETCH: if (!bus.ACKI_n) r_ir <= bus.IDT;
                S_EXEC: begin
                    r_result <= w_res;
                    r_npc    <= w_npc;
                    r_store  <= w_store;
                    r_wdst   <= w_wdst;
                    r_wen    <= w_wen;
                    r_write  <= w_wr;
                    r_sgn    <= w_sgn;
                    r_size   <= w_sz;
                end
                S_MEM:   if (!bus.ACKD_n && !r_write) r_result <= w_load;
                S_WB:    r_pc <= r_npc;
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_top_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_top_cpu
//  Description : Directed self-checking bench for top_cpu. A small program in
//                a behavioural instruction memory exercises ALU, stores, loads,
//                branch/jump and reset-during-access; register contents are
//                observed by storing them back out on the data bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_top_cpu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    wire  [31:0] ddt;
    logic        ddt_en  = 1'b0;
    logic [31:0] ddt_val = 32'h0;
    logic [31:0] imem [0:63];
    int          n_tests = 0;
    int          n_fail  = 0;

    top_cpu_if bus();

    top_cpu #(.RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .DDT (ddt)
    );

    assign ddt     = ddt_en ? ddt_val : 32'hzzzz_zzzz;
    assign bus.IDT = imem[bus.IAD[7:2]];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_mreq(input string tag);
        int k = 0;
        while (bus.MREQ !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'h0, bus.MREQ}, 32'h1);
    endtask

    task automatic wait_iad(input string tag, input logic [31:0] addr);
        int k = 0;
        while (bus.IAD !== addr && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(tag, bus.IAD, addr);
    endtask

    task automatic ack(input logic drive, input logic [31:0] val);
        ddt_en      = drive;
        ddt_val     = val;
        bus.ACKD_n  = 1'b0;
        @(negedge clk);
        bus.ACKD_n  = 1'b1;
        ddt_en      = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        imem[6'h00] = 32'h24017FFF; // 0x00 ADDIU r1,r0,0x7FFF
        imem[6'h01] = 32'h00211021; // 0x04 ADDU  r2,r1,r1
        imem[6'h02] = 32'h3C038000; // 0x08 LUI   r3,0x8000
        imem[6'h03] = 32'h00631821; // 0x0C ADDU  r3,r3,r3
        imem[6'h04] = 32'hAC020100; // 0x10 SW    r2,0x100(r0)
        imem[6'h05] = 32'h24040041; // 0x14 ADDIU r4,r0,0x41
        imem[6'h06] = 32'h3C05F000; // 0x18 LUI   r5,0xF000
        imem[6'h07] = 32'hA0A40000; // 0x1C SB    r4,0(r5)
        imem[6'h08] = 32'h1000FFFF; // 0x20 BEQ   r0,r0,-1
        imem[6'h10] = 32'h0C000020; // 0x40 JAL   0x80
        imem[6'h20] = 32'hAC1F0200; // 0x80 SW    r31,0x200(r0)
        imem[6'h21] = 32'hAC030104; // 0x84 SW    r3,0x104(r0)
        imem[6'h22] = 32'h80060000; // 0x88 LB    r6,0(r0)
        imem[6'h23] = 32'h90070000; // 0x8C LBU   r7,0(r0)
        imem[6'h24] = 32'hAC060108; // 0x90 SW    r6,0x108(r0)
        imem[6'h25] = 32'hAC07010C; // 0x94 SW    r7,0x10C(r0)
        imem[6'h26] = 32'h24000005; // 0x98 ADDIU r0,r0,5
        imem[6'h27] = 32'hAC000110; // 0x9C SW    r0,0x110(r0)
        imem[6'h28] = 32'h8C080000; // 0xA0 LW    r8,0(r0)
        bus.ACKI_n = 1'b0;
        bus.ACKD_n = 1'b1;
        bus.OINT_n = 3'b111;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_iad",   bus.IAD, 32'h0);
        check("rst_mreq",  {31'h0, bus.MREQ}, 32'h0);
        check("rst_write", {31'h0, bus.WRITE}, 32'h0);
        check("rst_size",  {30'h0, bus.SIZE}, 32'h0);
        check("rst_dad",   bus.DAD, 32'h0);
        check("rst_iack",  {31'h0, bus.IACK_n}, 32'h1);
        rst = 1'b0;

        // Three cycles per ALU instruction
        @(negedge clk);
        check("iad_exec0", bus.IAD, 32'h0);
        repeat (2) @(negedge clk);
        check("iad_next4", bus.IAD, 32'h4);

        // SW r2 -> 0x0000FFFE at 0x100
        wait_mreq("sw_r2_mreq");
        check("sw_r2_write", {31'h0, bus.WRITE}, 32'h1);
        check("sw_r2_size",  {30'h0, bus.SIZE}, 32'h0);
        check("sw_r2_dad",   bus.DAD, 32'h100);
        check("sw_r2_ddt",   ddt, 32'h0000FFFE);
        ack(1'b0, 32'h0);

        // SB 0x41 to stdout address
        wait_mreq("sb_mreq");
        check("sb_write", {31'h0, bus.WRITE}, 32'h1);
        check("sb_size",  {30'h0, bus.SIZE}, 32'h2);
        check("sb_dad",   bus.DAD, 32'hF0000000);
        check("sb_ddt",   ddt, 32'h00000041);
        ack(1'b0, 32'h0);

        // BEQ r0,r0,-1 loops on itself; then patch it into J 0x40
        wait_iad("beq_fetch", 32'h20);
        repeat (3) @(negedge clk);
        check("beq_loop", bus.IAD, 32'h20);
        imem[6'h08] = 32'h08000010;
        repeat (3) @(negedge clk);
        check("j_target", bus.IAD, 32'h40);
        repeat (3) @(negedge clk);
        check("jal_target", bus.IAD, 32'h80);

        wait_mreq("sw_r31_mreq");
        check("sw_r31_dad", bus.DAD, 32'h200);
        check("jal_link",   ddt, 32'h44);
        ack(1'b0, 32'h0);

        wait_mreq("sw_r3_mreq");
        check("sw_r3_dad", bus.DAD, 32'h104);
        check("addu_wrap", ddt, 32'h0);
        ack(1'b0, 32'h0);

        // LB with a stalled acknowledge
        wait_mreq("lb_mreq");
        check("lb_write", {31'h0, bus.WRITE}, 32'h0);
        check("lb_size",  {30'h0, bus.SIZE}, 32'h2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lb_hold_mreq", {31'h0, bus.MREQ}, 32'h1);
            check("lb_hold_dad",  bus.DAD, 32'h0);
            check("lb_hold_iad",  bus.IAD, 32'h88);
        end
        ack(1'b1, 32'h000000F0);

        wait_mreq("lbu_mreq");
        check("lbu_size", {30'h0, bus.SIZE}, 32'h2);
        ack(1'b1, 32'h000000F0);

        wait_mreq("sw_r6_mreq");
        check("lb_sext", ddt, 32'hFFFFFFF0);
        ack(1'b0, 32'h0);
        wait_mreq("sw_r7_mreq");
        check("lbu_zext", ddt, 32'h000000F0);
        ack(1'b0, 32'h0);
        wait_mreq("sw_r0_mreq");
        check("sw_r0_dad", bus.DAD, 32'h110);
        check("r0_zero",   ddt, 32'h0);
        ack(1'b0, 32'h0);

        // Reset in the middle of an LW access
        wait_mreq("lw_mreq");
        check("lw_size", {30'h0, bus.SIZE}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mem_mreq", {31'h0, bus.MREQ}, 32'h0);
        check("rst_mem_iad",  bus.IAD, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("restart_iad", bus.IAD, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/top_cpu.md
TOP_CPU -- requirements
Module: top_cpu

Interface
REQ-001 SHALL: clk  in  1  single system clock, all state updates on rising edge.
REQ-002 SHALL: rst  in  1  reset, synchronous and active-high.
REQ-003 SHALL: IAD  out  32  instruction byte address (PC).
REQ-004 SHALL: IDT  in  32  instruction word, big-endian, valid when ACKI_n=0.
REQ-005 SHALL: ACKI_n  in  1  active-low instruction acknowledge.
REQ-006 SHALL: DAD  out  32  data byte address.
REQ-007 SHALL: MREQ  out  1  data access request.
REQ-008 SHALL: WRITE  out  1  1=store, 0=load, meaningful only while MREQ=1.
REQ-009 SHALL: SIZE  out  2  access size: 00 word, 01 halfword, 10 byte.
REQ-010 SHALL: ACKD_n  in  1  active-low data acknowledge.
REQ-011 SHALL: DDT  inout  32  data bus, driven only while MREQ=1 and WRITE=1, otherwise high-Z.
REQ-012 SHALL: OINT_n  in  3  interrupt requests, ignored by this block.
REQ-013 SHALL: IACK_n  out  1  interrupt acknowledge, held at 1.
REQ-014 SHALL: parameter RESET_PC, default 32'h0, initial PC.

Function
REQ-015 SHALL: multicycle FSM, states FETCH -> EXEC -> (MEM if load/store) -> WB -> FETCH; no pipelining, no delay slots.
REQ-016 SHALL: FETCH drives IAD=PC and waits; on a rising edge with ACKI_n=0, latch IDT into IR and go to EXEC.
REQ-017 SHALL: EXEC decodes IR, reads rs/rt, computes ALU result, effective address (rs+sign-extended imm16) or branch/jump target.
REQ-018 SHALL: MEM asserts MREQ=1 with DAD, WRITE and SIZE held stable until a rising edge with ACKD_n=0, then go to WB.
REQ-019 SHALL: ACKD_n is ignored outside MEM; ACKI_n is ignored outside FETCH.
REQ-020 SHALL: stores drive DDT as word=rt[31:0], halfword=rt[15:0] in DDT[15:0], byte=rt[7:0] in DDT[7:0]; unused bits 0.
REQ-021 SHALL: loads capture DDT at ack; LW uses DDT[31:0]; LH/LB sign-extend and LHU/LBU zero-extend DDT[15:0]/DDT[7:0].
REQ-022 SHALL: no alignment check; DAD passed unmodified.
REQ-023 SHALL: WB writes rd (R-type), rt (I-type) or r31 (JAL), writes to r0 discarded, and updates PC (PC+4, branch target PC+4+(imm16<<2), jump {PC+4[31:28],idx26,00}, or rs for JR/JALR).
REQ-024 SHALL: ISA is a MIPS-I encoded subset: ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLL/SRL/SRA/SLLV/SRLV/SRAV/JR/JALR; ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI; LW/LH/LHU/LB/LBU/SW/SH/SB; BEQ/BNE; J/JAL.
REQ-025 SHALL: arithmetic is 32-bit wraparound with no overflow traps; ANDI/ORI/XORI zero-extend imm, others sign-extend.
REQ-026 SHALL: undefined opcodes execute as NOP (PC+4).
REQ-027 SHALL: JAL/JALR link value is PC+4.
REQ-028 SHALL: the exit (store to 32'hFF000000) and stdout (byte store to 32'hF0000000) addresses are ordinary stores to the block.

Reset
REQ-029 SHALL: while rst=1 at a rising edge, PC=RESET_PC, state=FETCH, IR=0, all 32 registers=0.
REQ-030 SHALL: reset values are MREQ=0, WRITE=0, SIZE=00, DAD=0, DDT high-Z, IACK_n=1.
REQ-031 SHALL: reset asserted mid-access abandons the access with no register or PC update.

Structure
REQ-032 SHALL: a shared package holds opcode/funct constants, SIZE encodings and FSM state enum.
REQ-033 SHALL: register file is the sub-module rf32x32 (2 async read ports, 1 sync write port, r0 reads 0).

Verification
REQ-034 SHALL: reset then ACKI_n=0 each cycle -> IAD=0, then 4 per 3-cycle ALU instruction (FETCH/EXEC/WB).
REQ-035 SHALL: ADDIU r1,r0,0x7FFF; ADDU r2,r1,r1 -> r2=0x0000FFFE; LUI r3,0x8000; ADDU r3,r3,r3 -> r3=0 with no trap.
REQ-036 SHALL: SW r2 to 0x100 -> MREQ=1, WRITE=1, SIZE=00, DAD=0x100, DDT=0x0000FFFE; SB of 0x41 to 0xF0000000 -> SIZE=10, DDT[7:0]=0x41.
REQ-037 SHALL: LB with DDT=0x000000F0 -> rt=0xFFFFFFF0; LBU -> 0x000000F0; ACKD_n held high 3 cycles -> MREQ/DAD stable, no WB until ack.
REQ-038 SHALL: BEQ r0,r0,-1 at 0x20 -> next IAD=0x20; JAL at 0x40 to 0x80 -> r31=0x44, IAD=0x80.
REQ-039 SHALL: ADDIU r0,r0,5 -> r0 reads 0; rst during MEM -> MREQ=0 next cycle, IAD=RESET_PC.
